// File: rtl/control_pkg.sv
// Branch predictor types, constants and the saturating counter helper.
package control_pkg;

    typedef enum logic {
        BP_IDLE     = 1'b0,
        BP_REDIRECT = 1'b1
    } e_bp_state;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } e_bp_counter;

    localparam int unsigned BP_PC_INC = 4;

    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) begin
                nxt = ctr + 2'd1;
            end else begin
                nxt = ctr;
            end
        end else begin
            if (ctr != SNT) begin
                nxt = ctr - 2'd1;
            end else begin
                nxt = ctr;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/instructions_pkg.sv
// Architectural constants shared by the fetch/execute blocks.
package instructions_pkg;
    localparam int unsigned XLEN = 32;
endpackage

// File: rtl/branch_history_table.sv
// Direct-mapped branch history table: one registered lookup port, one update port.
// Define BP_UPDATE_BYPASS_EN to forward a same-cycle same-index update to the lookup.
module branch_history_table
    import control_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_pc,
    output logic              rd_valid,
    output logic              rd_taken,
    output logic [DATA_W-1:0] rd_target,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_pc,
    input  logic              wr_taken,
    input  logic [DATA_W-1:0] wr_target
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    logic              valid_r  [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [1:0]        ctr_r    [ENTRIES];
    logic [DATA_W-1:0] target_r [ENTRIES];

    logic [IDX_W-1:0]  rd_idx_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [TAG_W-1:0]  wr_tag_s;
    logic              wr_hit_s;
    logic [1:0]        new_ctr_s;
    logic [DATA_W-1:0] new_target_s;
    logic              ent_valid_s;
    logic [TAG_W-1:0]  ent_tag_s;
    logic [1:0]        ent_ctr_s;
    logic [DATA_W-1:0] ent_target_s;
    logic              hit_taken_s;
    logic              rd_valid_r;
    logic              rd_taken_r;
    logic [DATA_W-1:0] rd_target_r;
    logic              unused_pc_bits;

    assign rd_idx_s       = rd_pc[IDX_W+1:2];
    assign rd_tag_s       = rd_pc[DATA_W-1:IDX_W+2];
    assign wr_idx_s       = wr_pc[IDX_W+1:2];
    assign wr_tag_s       = wr_pc[DATA_W-1:IDX_W+2];
    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0]};

    // Next contents of the entry being updated (allocate on miss, train on hit)
    always_comb begin
        wr_hit_s     = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);
        new_ctr_s    = WNT;
        new_target_s = wr_target;
        if (wr_hit_s) begin
            new_ctr_s    = bp_ctr_next(ctr_r[wr_idx_s], wr_taken);
            new_target_s = wr_taken ? wr_target : target_r[wr_idx_s];
        end else begin
            new_ctr_s    = wr_taken ? WT : WNT;
            new_target_s = wr_target;
        end
    end

    // Entry seen by the lookup, optionally including the in-flight update
    always_comb begin
        ent_valid_s  = valid_r[rd_idx_s];
        ent_tag_s    = tag_r[rd_idx_s];
        ent_ctr_s    = ctr_r[rd_idx_s];
        ent_target_s = target_r[rd_idx_s];
`ifdef BP_UPDATE_BYPASS_EN
        if (wr_en && (wr_idx_s == rd_idx_s)) begin
            ent_valid_s  = 1'b1;
            ent_tag_s    = wr_tag_s;
            ent_ctr_s    = new_ctr_s;
            ent_target_s = new_target_s;
        end else begin
            ent_valid_s  = valid_r[rd_idx_s];
        end
`endif
        hit_taken_s = ent_valid_s && (ent_tag_s == rd_tag_s) && ent_ctr_s[1];
    end

    // Table storage and update
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                ctr_r[i]    <= WNT;
                target_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            valid_r[wr_idx_s]  <= 1'b1;
            tag_r[wr_idx_s]    <= wr_tag_s;
            ctr_r[wr_idx_s]    <= new_ctr_s;
            target_r[wr_idx_s] <= new_target_s;
        end
    end

    // Registered lookup result; target forced to zero unless predicting taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_r  <= 1'b0;
            rd_taken_r  <= 1'b0;
            rd_target_r <= {DATA_W{1'b0}};
        end else begin
            rd_valid_r  <= rd_en;
            rd_taken_r  <= rd_en && hit_taken_s;
            rd_target_r <= (rd_en && hit_taken_s) ? ent_target_s : {DATA_W{1'b0}};
        end
    end

    assign rd_valid  = rd_valid_r;
    assign rd_taken  = rd_taken_r;
    assign rd_target = rd_target_r;

endmodule

// File: rtl/branch_predictor.sv
// Branch predictor top: BHT lookup/update plus mispredict redirect FSM.
// Optional BP_UPDATE_BYPASS_EN selects post-update lookup results on index collisions.
module branch_predictor
    import control_pkg::*;
#(
    parameter int DATA_W  = instructions_pkg::XLEN,
    parameter int ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              f_valid,
    input  logic [DATA_W-1:0] f_pc,
    output logic              p_valid,
    output logic              p_taken,
    output logic [DATA_W-1:0] p_target,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_pc,
    input  logic              r_taken,
    input  logic [DATA_W-1:0] r_target,
    input  logic              r_pred_taken,
    output logic              redirect_valid,
    output logic [DATA_W-1:0] redirect_pc,
    input  logic              redirect_ready
);

    e_bp_state         state_r;
    logic              redirect_valid_r;
    logic [DATA_W-1:0] redirect_pc_r;
    logic              r_ready_r;
    logic              accept_s;
    logic              mispredict_s;
    logic [DATA_W-1:0] redirect_target_s;

    assign accept_s          = r_valid && r_ready_r;
    assign mispredict_s      = accept_s && (r_taken != r_pred_taken);
    assign redirect_target_s = r_taken ? r_target : (r_pc + DATA_W'(BP_PC_INC));

    branch_history_table #(
        .DATA_W  (DATA_W),
        .ENTRIES (ENTRIES)
    ) u_bht (
        .clk       (clk),
        .rstn      (rstn),
        .rd_en     (f_valid),
        .rd_pc     (f_pc),
        .rd_valid  (p_valid),
        .rd_taken  (p_taken),
        .rd_target (p_target),
        .wr_en     (accept_s),
        .wr_pc     (r_pc),
        .wr_taken  (r_taken),
        .wr_target (r_target)
    );

    // Redirect FSM; resolutions are refused while a redirect is outstanding
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r          <= BP_IDLE;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {DATA_W{1'b0}};
            r_ready_r        <= 1'b1;
        end else begin
            case (state_r)
                BP_IDLE: begin
                    if (mispredict_s) begin
                        state_r          <= BP_REDIRECT;
                        redirect_valid_r <= 1'b1;
                        redirect_pc_r    <= redirect_target_s;
                        r_ready_r        <= 1'b0;
                    end
                end
                BP_REDIRECT: begin
                    if (redirect_ready) begin
                        state_r          <= BP_IDLE;
                        redirect_valid_r <= 1'b0;
                        r_ready_r        <= 1'b1;
                    end
                end
                default: begin
                    state_r          <= BP_IDLE;
                    redirect_valid_r <= 1'b0;
                    r_ready_r        <= 1'b1;
                end
            endcase
        end
    end

    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;
    assign r_ready        = r_ready_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// compared every cycle against a table-level reference model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        f_valid = 1'b0;
    logic [31:0] f_pc = 32'h0;
    logic        p_valid, p_taken;
    logic [31:0] p_target;
    logic        r_valid = 1'b0;
    logic        r_ready;
    logic [31:0] r_pc = 32'h0;
    logic        r_taken = 1'b0;
    logic [31:0] r_target = 32'h0;
    logic        r_pred_taken = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b1;

    branch_predictor #(.DATA_W(32), .ENTRIES(ENTRIES)) dut (
        .clk(clk), .rstn(rstn),
        .f_valid(f_valid), .f_pc(f_pc),
        .p_valid(p_valid), .p_taken(p_taken), .p_target(p_target),
        .r_valid(r_valid), .r_ready(r_ready), .r_pc(r_pc), .r_taken(r_taken),
        .r_target(r_target), .r_pred_taken(r_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: the table as plain arrays, counters as integers 0..3
    bit          m_v   [ENTRIES];
    logic [31:0] m_tag [ENTRIES];
    int          m_ctr [ENTRIES];
    logic [31:0] m_tgt [ENTRIES];
    bit          m_redirect;
    logic [31:0] m_rpc;
    bit          e_pv, e_pt;
    logic [31:0] e_ptgt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_lookup();
        int idx;
        logic [31:0] tg;
        idx    = int'((f_pc >> 2) % ENTRIES);
        tg     = f_pc >> (IDX_W + 2);
        e_pv   = f_valid;
        e_pt   = f_valid && m_v[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
        e_ptgt = e_pt ? m_tgt[idx] : 32'h0;
    endfunction

    function automatic void m_update();
        int idx;
        logic [31:0] tg;
        idx = int'((r_pc >> 2) % ENTRIES);
        tg  = r_pc >> (IDX_W + 2);
        if (m_v[idx] && m_tag[idx] == tg) begin
            if (r_taken) begin
                m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
                m_tgt[idx] = r_target;
            end else begin
                m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            end
        end else begin
            m_v[idx]   = 1'b1;
            m_tag[idx] = tg;
            m_ctr[idx] = r_taken ? 2 : 1;
            m_tgt[idx] = r_target;
        end
    endfunction

    always @(posedge clk or negedge rstn) begin
        bit acc, was_redirect;
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                m_v[i] = 1'b0; m_ctr[i] = 1; m_tag[i] = 32'h0; m_tgt[i] = 32'h0;
            end
            m_redirect = 1'b0; m_rpc = 32'h0;
            e_pv = 1'b0; e_pt = 1'b0; e_ptgt = 32'h0;
        end else begin
            was_redirect = m_redirect;
            acc = r_valid && !m_redirect;
`ifdef BP_UPDATE_BYPASS_EN
            if (acc) m_update();
            m_lookup();
`else
            m_lookup();
            if (acc) m_update();
`endif
            if (was_redirect) begin
                if (redirect_ready) m_redirect = 1'b0;
            end else if (acc && (r_taken != r_pred_taken)) begin
                m_redirect = 1'b1;
                m_rpc = r_taken ? r_target : r_pc + 32'd4;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en && rstn) begin
            check("p_valid", 32'(p_valid), 32'(e_pv));
            if (!e_pv) begin
                check("p_taken_idle", 32'(p_taken), 32'h0);
                check("p_target_idle", p_target, 32'h0);
            end else begin
                check("p_taken", 32'(p_taken), 32'(e_pt));
                if (e_pt) check("p_target", p_target, e_ptgt);
            end
            check("redirect_valid", 32'(redirect_valid), 32'(m_redirect));
            check("r_ready", 32'(r_ready), 32'(!m_redirect));
            if (m_redirect) check("redirect_pc", redirect_pc, m_rpc);
        end
    end

    task automatic drive(input bit fv, input logic [31:0] fpc, input bit rv,
                         input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                         input bit rp, input bit rr);
        f_valid = fv; f_pc = fpc; r_valid = rv; r_pc = rpc; r_taken = rt;
        r_target = rtgt; r_pred_taken = rp; redirect_ready = rr;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_pc();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
        return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_p_valid", 32'(p_valid), 32'h0);
        check("rst_p_taken", 32'(p_taken), 32'h0);
        check("rst_p_target", p_target, 32'h0);
        check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_r_ready", 32'(r_ready), 32'h1);
        #1 rstn = 1'b1;
        chk_en = 1'b1;

        // Cold lookup predicts not-taken
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("cold_p_valid", 32'(p_valid), 32'h1);
        check("cold_p_taken", 32'(p_taken), 32'h0);

        // Taken mispredict allocates and redirects to the target
        drive(0, 0, 1, 32'h100, 1, 32'h200, 0, 1);
        check("alloc_redirect_valid", 32'(redirect_valid), 32'h1);
        check("alloc_redirect_pc", redirect_pc, 32'h200);
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("alloc_p_taken", 32'(p_taken), 32'h1);
        check("alloc_p_target", p_target, 32'h200);
        check("alloc_back_idle", 32'(redirect_valid), 32'h0);

        // Four not-taken outcomes saturate at SNT
        repeat (4) drive(0, 0, 1, 32'h100, 0, 32'hDEAD_0000, 0, 1);
        check("model_ctr_snt", 32'(m_ctr[0]), 32'h0);
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("snt_p_taken", 32'(p_taken), 32'h0);

        // Not-taken mispredict held for three cycles with redirect_ready low
        drive(0, 0, 1, 32'h100, 0, 32'h0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            check("hold_redirect_valid", 32'(redirect_valid), 32'h1);
            check("hold_redirect_pc", redirect_pc, 32'h104);
            check("hold_r_ready", 32'(r_ready), 32'h0);
            if (i == 0) drive(0, 0, 1, 32'h100, 1, 32'h999, 0, 0);
            else if (i == 1) drive(0, 0, 0, 0, 0, 0, 0, 0);
        end
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("hold_release_idle", 32'(redirect_valid), 32'h0);
        check("hold_release_ready", 32'(r_ready), 32'h1);
        check("stalled_res_ignored", 32'(p_taken), 32'h0);

        // Alias 0x200 shares index 0 with 0x100 and evicts it
        drive(0, 0, 1, 32'h200, 1, 32'h300, 1, 1);
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("alias_orig_p_taken", 32'(p_taken), 32'h0);
        drive(1, 32'h200, 0, 0, 0, 0, 0, 1);
        check("alias_new_p_taken", 32'(p_taken), 32'h1);
        check("alias_new_p_target", p_target, 32'h300);

        // Fall-through redirect wraps at the top of the address space
        drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 1);
        check("wrap_redirect_valid", 32'(redirect_valid), 32'h1);
        check("wrap_redirect_pc", redirect_pc, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 1);

        // Reset during REDIRECT drops the redirect and clears the table
        drive(0, 0, 1, 32'h100, 1, 32'h500, 0, 0);
        check("pre_rst_redirect_pc", redirect_pc, 32'h500);
        #1 rstn = 1'b0;
        #1;
        check("rst_mid_redirect_valid", 32'(redirect_valid), 32'h0);
        check("rst_mid_r_ready", 32'(r_ready), 32'h1);
        @(negedge clk); #2 rstn = 1'b1;
        drive(1, 32'h100, 0, 0, 0, 0, 0, 1);
        check("post_rst_p_valid", 32'(p_valid), 32'h1);
        check("post_rst_p_taken", 32'(p_taken), 32'h0);

        // Randomized traffic over a small aliasing PC pool
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 1) == 1, pick_pc(),
                  $urandom_range(0, 1) == 1, pick_pc(),
                  $urandom_range(0, 1) == 1, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                  $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATA_W, default instructions_pkg::XLEN (32), address/data width.
REQ-002 SHALL have parameter ENTRIES, default 64, table depth; power of two, IDX_W = log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port f_valid, input, 1, fetch lookup request.
REQ-006 SHALL have port f_pc, input, DATA_W, fetch PC to look up.
REQ-007 SHALL have port p_valid, output, 1, prediction valid, one cycle after f_valid.
REQ-008 SHALL have port p_taken, output, 1, predicted taken.
REQ-009 SHALL have port p_target, output, DATA_W, predicted target, meaningful only when p_taken=1.
REQ-010 SHALL have port r_valid, input, 1, branch resolution from the execute-stage comparator.
REQ-011 SHALL have port r_ready, output, 1, resolution accepted when r_valid and r_ready are both high.
REQ-012 SHALL have port r_pc, input, DATA_W, PC of the resolved branch.
REQ-013 SHALL have port r_taken, input, 1, actual outcome (comparator result equals taken).
REQ-014 SHALL have port r_target, input, DATA_W, computed branch target.
REQ-015 SHALL have port r_pred_taken, input, 1, prediction carried down the pipe with the branch.
REQ-016 SHALL have port redirect_valid, output, 1, fetch redirect request.
REQ-017 SHALL have port redirect_pc, output, DATA_W, PC to refetch from.
REQ-018 SHALL have port redirect_ready, input, 1, fetch accepts the redirect.

Function
REQ-019 SHALL use entry index f_pc/r_pc[IDX_W+1:2] and tag pc[DATA_W-1:IDX_W+2]; each entry holds a valid bit, tag, 2-bit counter and DATA_W target.
REQ-020 SHALL register the lookup: p_valid = f_valid delayed one cycle; p_taken = entry valid AND tag match AND counter[1].
REQ-021 SHALL drive p_taken=0 and p_target=0 when p_valid=0.
REQ-022 SHALL use a 2-bit saturating counter: taken increments, saturating at ST(11); not-taken decrements, saturating at SNT(00).
REQ-023 SHALL, on an accepted resolution with a tag miss or invalid entry, allocate the entry: valid=1, tag written, counter=WT(10) if taken else WNT(01), target=r_target.
REQ-024 SHALL, on an accepted resolution with a tag hit, update the counter and write target=r_target only when r_taken=1.
REQ-025 SHALL detect a mispredict when r_taken != r_pred_taken on an accepted resolution.
REQ-026 SHALL implement FSM IDLE -> REDIRECT on mispredict; REDIRECT -> IDLE when redirect_ready=1; no other transitions.
REQ-027 SHALL set redirect_pc = r_target if r_taken, else r_pc+4 (modulo 2^DATA_W, so 0xFFFFFFFC wraps to 0x0), latched on entry to REDIRECT.
REQ-028 SHALL hold redirect_valid=1 and redirect_pc stable in REDIRECT; redirect_valid=0 in IDLE.
REQ-029 SHALL drive r_ready=1 in IDLE and 0 in REDIRECT; resolutions stall until the redirect is accepted.
REQ-030 SHALL perform the table update in the same cycle the resolution is accepted, independent of the mispredict outcome.
REQ-031 SHALL, on a lookup and an update to the same index in the same cycle, return the pre-update entry (see Configuration).

Reset
REQ-032 SHALL, while rstn=0, clear all valid bits, set all counters to WNT, and force the FSM to IDLE.
REQ-033 SHALL drive p_valid=0, p_taken=0, p_target=0, redirect_valid=0, redirect_pc=0 and r_ready=1 from reset.
REQ-034 SHALL, on reset asserted during REDIRECT, drop the pending redirect without emitting it.

Configuration
REQ-035 SHALL, with BP_UPDATE_BYPASS_EN defined, forward a same-cycle same-index update to the lookup so that the post-update entry is returned.
REQ-036 SHALL, without BP_UPDATE_BYPASS_EN, return the pre-update entry as stated in REQ-031.

Structure
REQ-037 SHALL declare in control_pkg: enum e_bp_state {BP_IDLE, BP_REDIRECT}; enum e_bp_counter {SNT, WNT, WT, ST}; constant BP_PC_INC=4.
REQ-038 SHALL place the storage and update logic in sub-module branch_history_table (1 read port, 1 write port); FSM and redirect logic stay in branch_predictor.

Verification
REQ-039 SHALL cover: after reset, lookup f_pc=0x100 -> p_valid=1, p_taken=0 next cycle.
REQ-040 SHALL cover: resolve pc=0x100, taken=1, target=0x200, pred=0 -> redirect_pc=0x200; lookup 0x100 -> p_taken=1, p_target=0x200.
REQ-041 SHALL cover: four not-taken resolutions of 0x100 from WT -> counter reaches SNT and stays there; p_taken=0.
REQ-042 SHALL cover: resolve pc=0x100, taken=0, pred=1 with redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc=0x104 held, r_ready=0 for 3 cycles, return to IDLE on ready.
REQ-043 SHALL cover: alias pc=0x100 and pc=0x100+4*ENTRIES -> tag miss, entry reallocated, and the original PC then predicts not-taken.
REQ-044 SHALL cover: rstn pulsed low during REDIRECT -> redirect_valid=0 immediately; lookup of 0x100 -> p_taken=0.
